// File: rtl/rc_uart_pkg.sv
// Shared definitions for the UART-side blocks of the root calculator.
//   - ASCII constants used by the line parser
//   - parser FSM state encoding
//   - byte classification helper
package rc_uart_pkg;

  localparam logic [7:0] ASCII_0   = 8'h30;
  localparam logic [7:0] ASCII_9   = 8'h39;
  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_ESC = 8'h1B;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ACCUM   = 2'b01,
    DISCARD = 2'b10
  } parse_state_t;

  typedef enum logic [1:0] {
    CLS_DIGIT,
    CLS_TERM,
    CLS_ESC,
    CLS_OTHER
  } byte_class_t;

  function automatic byte_class_t classify_byte(input logic [7:0] b);
    if (b >= ASCII_0 && b <= ASCII_9)       return CLS_DIGIT;
    else if (b == ASCII_CR || b == ASCII_LF) return CLS_TERM;
    else if (b == ASCII_ESC)                 return CLS_ESC;
    else                                     return CLS_OTHER;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// 1-bit registered rising-edge detector.
//   clk   : clock
//   rst_n : asynchronous active-low reset (clears history)
//   din   : level input
//   pulse : high for the cycle in which din is 1 and was 0 last cycle
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic din_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) din_q <= 1'b0;
    else        din_q <= din;
  end

  assign pulse = din & ~din_q;

endmodule

// File: rtl/rs232_number_parser.sv
// Converts a CR/LF-terminated line of ASCII decimal digits from the RS232
// receiver into an unsigned WIDTH-bit operand.
//   clk           : system clock
//   rst_n         : asynchronous active-low reset
//   rx_data       : received byte, valid while rx_ready is high
//   rx_ready      : receiver byte-ready level
//   rx_error      : receiver framing/start error level
//   operand       : last successfully parsed value
//   operand_valid : one-cycle strobe when operand updates
//   parse_error   : one-cycle strobe when a line is rejected
//   busy          : FSM is mid-line
module rs232_number_parser
  import rc_uart_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_ready,
  input  logic             rx_error,
  output logic [WIDTH-1:0] operand,
  output logic             operand_valid,
  output logic             parse_error,
  output logic             busy
);

  logic byte_evt;
  logic err_evt;

  rise_detect u_ready_rise (.clk(clk), .rst_n(rst_n), .din(rx_ready), .pulse(byte_evt));
  rise_detect u_error_rise (.clk(clk), .rst_n(rst_n), .din(rx_error), .pulse(err_evt));

  parse_state_t     state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [7:0]       digit_cnt_q, digit_cnt_d;
  logic [WIDTH-1:0] operand_d;
  logic             valid_d, error_d;

  byte_class_t      cls;
  logic [WIDTH+3:0] acc_ext;
  logic [WIDTH+3:0] digit_ext;
  logic [WIDTH+3:0] ext;
  logic             byte_ok;

  assign cls       = classify_byte(rx_data);
  // An error edge in the same cycle as a byte edge drops the byte.
  assign byte_ok   = byte_evt & ~err_evt;
  assign acc_ext   = {4'b0000, acc_q};
  assign digit_ext = {{WIDTH{1'b0}}, rx_data[3:0]};
  assign ext       = (acc_ext << 3) + (acc_ext << 1) + digit_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      digit_cnt_q   <= '0;
      operand       <= '0;
      operand_valid <= 1'b0;
      parse_error   <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      digit_cnt_q   <= digit_cnt_d;
      operand       <= operand_d;
      operand_valid <= valid_d;
      parse_error   <= error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    digit_cnt_d = digit_cnt_q;
    operand_d   = operand;
    valid_d     = 1'b0;
    error_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (err_evt) begin
          state_d = DISCARD;
        end else if (byte_ok) begin
          unique case (cls)
            CLS_DIGIT: begin
              acc_d       = {{(WIDTH-4){1'b0}}, rx_data[3:0]};
              digit_cnt_d = 8'd1;
              state_d     = ACCUM;
            end
            CLS_OTHER: state_d = DISCARD;
            default: ;
          endcase
        end
      end

      ACCUM: begin
        if (err_evt) begin
          state_d = DISCARD;
        end else if (byte_ok) begin
          unique case (cls)
            CLS_DIGIT: begin
              if (ext[WIDTH+3:WIDTH] != 4'b0000) begin
                state_d = DISCARD;
              end else begin
                acc_d = ext[WIDTH-1:0];
                if (digit_cnt_q != 8'hFF) digit_cnt_d = digit_cnt_q + 8'd1;
              end
            end
            CLS_TERM: begin
              operand_d   = acc_q;
              valid_d     = 1'b1;
              acc_d       = '0;
              digit_cnt_d = '0;
              state_d     = IDLE;
            end
            CLS_ESC: begin
              acc_d       = '0;
              digit_cnt_d = '0;
              state_d     = IDLE;
            end
            default: state_d = DISCARD;
          endcase
        end
      end

      DISCARD: begin
        if (byte_ok) begin
          if (cls == CLS_TERM) begin
            error_d     = 1'b1;
            acc_d       = '0;
            digit_cnt_d = '0;
            state_d     = IDLE;
          end else if (cls == CLS_ESC) begin
            acc_d       = '0;
            digit_cnt_d = '0;
            state_d     = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_rs232_number_parser.sv
module tb_rs232_number_parser;

  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       rx_data;
  logic             rx_ready;
  logic             rx_error;
  logic [WIDTH-1:0] operand;
  logic             operand_valid;
  logic             parse_error;
  logic             busy;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  rs232_number_parser #(.WIDTH(WIDTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_data       (rx_data),
    .rx_ready      (rx_ready),
    .rx_error      (rx_error),
    .operand       (operand),
    .operand_valid (operand_valid),
    .parse_error   (parse_error),
    .busy          (busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents one byte as a receiver would: rx_ready held high for several
  // cycles. Returns the strobes seen one cycle after the byte event and
  // checks that they are gone the cycle after that.
  task automatic send_byte(input logic [7:0] b, input logic with_err,
                           output logic v, output logic e);
    rx_data  = b;
    rx_ready = 1'b1;
    rx_error = with_err;
    @(negedge clk);
    v = operand_valid;
    e = parse_error;
    @(negedge clk);
    check_eq("strobe_width", {62'd0, operand_valid, parse_error}, 64'd0);
    repeat (2) @(negedge clk);
    rx_ready = 1'b0;
    rx_error = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_line(input string s, input logic exp_v, input logic exp_e,
                           input logic [WIDTH-1:0] exp_op);
    logic v, e;
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i], 1'b0, v, e);
      if (i == s.len() - 1) begin
        check_eq({"last_valid ", s}, {63'd0, v}, {63'd0, exp_v});
        check_eq({"last_error ", s}, {63'd0, e}, {63'd0, exp_e});
      end else begin
        check_eq({"mid_strobe ", s}, {62'd0, v, e}, 64'd0);
      end
    end
    check_eq({"operand ", s}, {32'd0, operand}, {32'd0, exp_op});
  endtask

  task automatic pulse_rx_error();
    rx_error = 1'b1;
    repeat (4) @(negedge clk);
    rx_error = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic v, e;
    rst_n    = 1'b0;
    rx_data  = 8'h00;
    rx_ready = 1'b0;
    rx_error = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_operand", {32'd0, operand}, 64'd0);
    check_eq("rst_valid",   {63'd0, operand_valid}, 64'd0);
    check_eq("rst_error",   {63'd0, parse_error}, 64'd0);
    check_eq("rst_busy",    {63'd0, busy}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic line
    send_line("1234\r", 1'b1, 1'b0, 32'h0000_04D2);

    // Max value, CR LF pair, then overflow by one
    send_line("4294967295\r", 1'b1, 1'b0, 32'hFFFF_FFFF);
    send_line("\n", 1'b0, 1'b0, 32'hFFFF_FFFF);
    send_line("4294967296", 1'b0, 1'b0, 32'hFFFF_FFFF);
    check_eq("busy_overflow", {63'd0, busy}, 64'd1);
    send_line("\r", 1'b0, 1'b1, 32'hFFFF_FFFF);

    // Malformed line then LF-terminated good line; leading zeros
    send_line("12a3\r", 1'b0, 1'b1, 32'hFFFF_FFFF);
    send_line("7\n", 1'b1, 1'b0, 32'd7);
    send_line("0009\r", 1'b1, 1'b0, 32'd9);
    send_line("7\r", 1'b1, 1'b0, 32'd7);

    // Framing error mid-line
    send_line("55", 1'b0, 1'b0, 32'd7);
    pulse_rx_error();
    check_eq("busy_discard", {63'd0, busy}, 64'd1);
    send_line("6\r", 1'b0, 1'b1, 32'd7);

    // Framing error coincident with a byte edge
    send_line("55", 1'b0, 1'b0, 32'd7);
    send_byte("6", 1'b1, v, e);
    check_eq("coincident_strobe", {62'd0, v, e}, 64'd0);
    check_eq("busy_coincident", {63'd0, busy}, 64'd1);
    send_line("\r", 1'b0, 1'b1, 32'd7);
    check_eq("idle_after_reject", {63'd0, busy}, 64'd0);

    // Escape abort
    send_line("98", 1'b0, 1'b0, 32'd7);
    check_eq("busy_accum", {63'd0, busy}, 64'd1);
    send_line("\033", 1'b0, 1'b0, 32'd7);
    check_eq("busy_after_esc", {63'd0, busy}, 64'd0);
    send_line("3\r", 1'b1, 1'b0, 32'd3);

    // Reset mid-line
    send_line("98", 1'b0, 1'b0, 32'd3);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("midrst_operand", {32'd0, operand}, 64'd0);
    check_eq("midrst_valid",   {63'd0, operand_valid}, 64'd0);
    check_eq("midrst_error",   {63'd0, parse_error}, 64'd0);
    check_eq("midrst_busy",    {63'd0, busy}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_line("\r", 1'b0, 1'b0, 32'd0);
    send_line("41\r", 1'b1, 1'b0, 32'd41);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
